// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one bus master between fetch and execute, data-first with a starvation guard
// and a per-transaction timeout that turns a hung access into an error response.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic        m_write,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ack,
  input  logic [31:0] m_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;
  state_t r_state, w_next;
  logic r_owner;
  logic [SW-1:0] r_starve;
  logic [CNT_W-1:0] r_tmo;
  logic w_grant_d, w_grant_i, w_done;
  always_comb begin
    w_grant_d = r_state == IDLE && d_req && (!i_req || r_starve < STARVE_MAX);
    w_grant_i = r_state == IDLE && i_req && !w_grant_d;
    w_done    = r_state == BUSY && (m_ack || (TIMEOUT != 0 && r_tmo == TMO_LAST));
    w_next    = r_state == RESPOND ? IDLE :
                w_done ? RESPOND :
                (w_grant_d || w_grant_i) ? BUSY : r_state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner  <= 1'b0;
      r_starve <= '0;
      r_tmo    <= '0;
      m_req    <= 1'b0;
      m_addr   <= '0;
      m_write  <= 1'b0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      i_ack    <= 1'b0;
      i_rdata  <= '0;
      i_err    <= 1'b0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      if (w_grant_d || w_grant_i) begin
        r_owner  <= w_grant_i;
        r_starve <= (w_grant_d && i_req) ? r_starve + 1'b1 : '0;
        r_tmo    <= '0;
        m_req    <= 1'b1;
        m_addr   <= w_grant_i ? i_addr : d_addr;
        m_write  <= w_grant_d && d_write;
        m_wdata  <= w_grant_d ? d_wdata : '0;
        m_wstrb  <= w_grant_d ? d_wstrb : '0;
      end
      // A timeout completes like an ack but with zero data and the error flag set.
      if (w_done) begin
        m_req   <= 1'b0;
        i_ack   <= r_owner;
        d_ack   <= !r_owner;
        i_rdata <= (r_owner && m_ack) ? m_rdata : '0;
        d_rdata <= (!r_owner && m_ack) ? m_rdata : '0;
        i_err   <= r_owner && !m_ack;
        d_err   <= !r_owner && !m_ack;
      end else if (r_state == BUSY) r_tmo <= r_tmo + 1'b1;
      if (r_state == RESPOND) begin
        i_ack   <= 1'b0;
        d_ack   <= 1'b0;
        i_rdata <= '0;
        d_rdata <= '0;
        i_err   <= 1'b0;
        d_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus a randomized run checked against a transaction-level model.
module tb_mem_bus_arbiter;
  logic clock = 1'b0, reset = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_write = 1'b0, m_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [3:0] d_wstrb = '0;
  logic i_ack, i_err, d_ack, d_err, m_req, m_write;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0] m_wstrb;
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    i_req = 1'b1; i_addr = 32'h44; m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    tests++;
    if ({m_req, m_write, m_addr, m_wdata, m_wstrb} !== 70'd0) begin
      fails++; $display("FAIL reset_m got %b %b %h %h %h exp all 0", m_req, m_write, m_addr, m_wdata, m_wstrb);
    end
    tests++;
    if ({i_ack, i_err, i_rdata, d_ack, d_err, d_rdata} !== 68'd0) begin
      fails++; $display("FAIL reset_resp got %b %b %h %b %b %h exp all 0", i_ack, i_err, i_rdata, d_ack, d_err, d_rdata);
    end
    i_req = 1'b0; m_ack = 1'b0;
    reset = 1'b1;
    tick();
    tests++;
    if ({m_req, i_ack, d_ack} !== 3'b000) begin
      fails++; $display("FAIL reset_release got %b exp 000", {m_req, i_ack, d_ack});
    end
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    tests++;
    if ({m_req, m_write, m_addr} !== {1'b1, 1'b0, 32'h100}) begin
      fails++; $display("FAIL fetch_bus got m_req=%b m_write=%b m_addr=%h exp 1 0 00000100", m_req, m_write, m_addr);
    end
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    tick();
    tests++;
    if ({i_ack, i_err, i_rdata, d_ack, m_req} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      fails++; $display("FAIL fetch_ack got i_ack=%b i_err=%b i_rdata=%h d_ack=%b m_req=%b exp 1 0 deadbeef 0 0", i_ack, i_err, i_rdata, d_ack, m_req);
    end
    i_req = 1'b0; m_ack = 1'b0;
    tick();
    tests++;
    if ({i_ack, d_ack, m_req} !== 3'b000) begin
      fails++; $display("FAIL fetch_idle got %b exp 000", {i_ack, d_ack, m_req});
    end
  endtask

  task automatic test_store();
    int acks = 0;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    tick();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({m_req, m_write, m_addr, m_wdata, m_wstrb, d_ack} !== {1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'hF, 1'b0}) begin
        fails++; $display("FAIL store_busy%0d got %b %b %h %h %h ack=%b exp 1 1 00002000 12345678 f 0", k, m_req, m_write, m_addr, m_wdata, m_wstrb, d_ack);
      end
      m_ack = (k == 3); m_rdata = 32'h55AA_55AA;
      tick();
    end
    m_ack = 1'b0; d_req = 1'b0; d_write = 1'b0;
    acks += int'(d_ack);
    tests++;
    if ({d_ack, d_err, d_rdata, i_ack, m_req} !== {1'b1, 1'b0, 32'h55AA_55AA, 1'b0, 1'b0}) begin
      fails++; $display("FAIL store_ack got d_ack=%b d_err=%b d_rdata=%h i_ack=%b m_req=%b exp 1 0 55aa55aa 0 0", d_ack, d_err, d_rdata, i_ack, m_req);
    end
    tick();
    acks += int'(d_ack);
    tick();
    acks += int'(d_ack);
    tests++;
    if (acks !== 1) begin
      fails++; $display("FAIL store_pulses got %0d exp 1", acks);
    end
  endtask

  task automatic test_contention();
    logic exp_i;
    i_addr = 32'h1000; d_addr = 32'h2000; d_write = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_i = (k % 5 == 4);
      tick();
      tests++;
      if ({m_req, m_addr} !== {1'b1, exp_i ? 32'h1000 : 32'h2000}) begin
        fails++; $display("FAIL contention_grant%0d got m_req=%b m_addr=%h exp owner %s", k, m_req, m_addr, exp_i ? "I" : "D");
      end
      m_ack = 1'b1; m_rdata = k;
      tick();
      tests++;
      if ({i_ack, d_ack} !== {exp_i, !exp_i}) begin
        fails++; $display("FAIL contention_ack%0d got i_ack=%b d_ack=%b exp %b %b", k, i_ack, d_ack, exp_i, !exp_i);
      end
      m_ack = 1'b0;
      if (k == 9) begin i_req = 1'b0; d_req = 1'b0; end
      tick();
    end
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h3000; m_rdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++;
      if ({m_req, d_ack, i_ack} !== 3'b100) begin
        fails++; $display("FAIL timeout_busy%0d got m_req=%b d_ack=%b i_ack=%b exp 1 0 0", k, m_req, d_ack, i_ack);
      end
    end
    tick();
    tests++;
    if ({m_req, d_ack, d_err, d_rdata, i_ack} !== {1'b0, 1'b1, 1'b1, 32'h0, 1'b0}) begin
      fails++; $display("FAIL timeout_resp got m_req=%b d_ack=%b d_err=%b d_rdata=%h i_ack=%b exp 0 1 1 0 0", m_req, d_ack, d_err, d_rdata, i_ack);
    end
    d_req = 1'b0; m_ack = 1'b1;
    tick();
    tests++;
    if ({m_req, d_ack, i_ack, d_err} !== 4'b0000) begin
      fails++; $display("FAIL timeout_late_ack got %b exp 0000", {m_req, d_ack, i_ack, d_err});
    end
    m_ack = 1'b0;
    tick();
    tests++;
    if ({m_req, d_ack, i_ack} !== 3'b000) begin
      fails++; $display("FAIL timeout_after got %b exp 000", {m_req, d_ack, i_ack});
    end
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_addr = 32'h5000; d_req = 1'b1; d_addr = 32'h4000; d_write = 1'b1; d_wdata = 32'hA5A5_A5A5; d_wstrb = 4'h3;
    tick();
    tests++;
    if ({m_req, m_addr} !== {1'b1, 32'h4000}) begin
      fails++; $display("FAIL rstmid_grant got m_req=%b m_addr=%h exp 1 00004000", m_req, m_addr);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({m_req, m_write, m_addr, m_wdata, m_wstrb, i_ack, i_err, i_rdata, d_ack, d_err, d_rdata} !== 138'd0) begin
      fails++; $display("FAIL rstmid_async got m_req=%b m_addr=%h m_wdata=%h exp all 0", m_req, m_addr, m_wdata);
    end
    @(negedge clock);
    d_req = 1'b0; d_write = 1'b0;
    reset = 1'b1;
    tick();
    tests++;
    if ({m_req, m_write, m_addr, m_wdata, m_wstrb} !== {1'b1, 1'b0, 32'h5000, 32'h0, 4'h0}) begin
      fails++; $display("FAIL rstmid_fresh got %b %b %h %h %h exp 1 0 00005000 0 0", m_req, m_write, m_addr, m_wdata, m_wstrb);
    end
    m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
    tick();
    tests++;
    if ({i_ack, i_rdata, d_ack} !== {1'b1, 32'h0BAD_F00D, 1'b0}) begin
      fails++; $display("FAIL rstmid_ack got i_ack=%b i_rdata=%h d_ack=%b exp 1 0badf00d 0", i_ack, i_rdata, d_ack);
    end
    i_req = 1'b0; m_ack = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    i_req = 1'b1; i_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if ({m_req, m_addr} !== {1'b1, 32'(k * 4)}) begin
        fails++; $display("FAIL b2b_addr%0d got m_req=%b m_addr=%h exp 1 %h", k, m_req, m_addr, 32'(k * 4));
      end
      m_ack = 1'b1; m_rdata = 32'hA000_0000 + 32'(k);
      tick();
      tests++;
      if ({i_ack, i_err, i_rdata} !== {1'b1, 1'b0, 32'hA000_0000 + 32'(k)}) begin
        fails++; $display("FAIL b2b_ack%0d got i_ack=%b i_err=%b i_rdata=%h", k, i_ack, i_err, i_rdata);
      end
      m_ack = 1'b0;
      if (k == 2) i_req = 1'b0;
      else i_addr = 32'((k + 1) * 4);
      tick();
      tests++;
      if ({m_req, i_ack} !== 2'b00) begin
        fails++; $display("FAIL b2b_idle%0d got m_req=%b i_ack=%b exp 0 0", k, m_req, i_ack);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 600;
    int resp_cyc = -1, grant_cyc = 0, wait_n = 0, starve = 0, resp;
    bit busy = 0, owner_i = 0, exp_err = 0, done_now, gen, gd;
    logic [31:0] exp_addr = '0, exp_wd = '0, exp_rd = '0;
    logic [3:0] exp_ws = '0;
    logic exp_w = 1'b0;
    for (int c = 1; c <= N; c++) begin
      tick();
      done_now = 0;
      if (!busy && c - 1 > resp_cyc && (i_req || d_req)) begin
        gd = d_req && (!i_req || starve < 4);
        owner_i = !gd;
        starve = (gd && i_req) ? starve + 1 : 0;
        busy = 1; grant_cyc = c; wait_n = $urandom_range(0, 10);
        exp_err = (wait_n >= 8); exp_rd = '0;
        exp_addr = owner_i ? i_addr : d_addr;
        exp_w = gd && d_write;
        exp_wd = gd ? d_wdata : '0;
        exp_ws = gd ? d_wstrb : '0;
        tests++;
        if ({m_req, m_addr, m_write, m_wdata, m_wstrb, i_ack, d_ack} !== {1'b1, exp_addr, exp_w, exp_wd, exp_ws, 2'b00}) begin
          fails++; $display("FAIL rand_grant c=%0d got m_req=%b m_addr=%h m_write=%b exp owner %s addr %h", c, m_req, m_addr, m_write, owner_i ? "I" : "D", exp_addr);
        end
      end else if (!busy) begin
        tests++;
        if ({m_req, i_ack, d_ack} !== 3'b000) begin
          fails++; $display("FAIL rand_idle c=%0d got m_req=%b i_ack=%b d_ack=%b exp 0 0 0", c, m_req, i_ack, d_ack);
        end
      end else begin
        resp = grant_cyc + (wait_n < 8 ? wait_n + 1 : 8);
        tests++;
        if (c < resp) begin
          if ({m_req, m_addr, m_write, m_wdata, m_wstrb, i_ack, d_ack} !== {1'b1, exp_addr, exp_w, exp_wd, exp_ws, 2'b00}) begin
            fails++; $display("FAIL rand_busy c=%0d got m_req=%b m_addr=%h i_ack=%b d_ack=%b exp 1 %h 0 0", c, m_req, m_addr, i_ack, d_ack, exp_addr);
          end
        end else begin
          if ({m_req, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata} !==
              {1'b0, owner_i, !owner_i, owner_i && exp_err, !owner_i && exp_err, owner_i ? exp_rd : 32'h0, owner_i ? 32'h0 : exp_rd}) begin
            fails++; $display("FAIL rand_resp c=%0d got m_req=%b i_ack=%b d_ack=%b i_err=%b d_err=%b i_rdata=%h d_rdata=%h exp owner %s err %b rdata %h",
                              c, m_req, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata, owner_i ? "I" : "D", exp_err, exp_rd);
          end
          busy = 0; resp_cyc = c; done_now = 1;
        end
      end
      m_ack = 1'b0; m_rdata = $urandom;
      if (busy && wait_n < 8 && c - grant_cyc == wait_n) begin m_ack = 1'b1; exp_rd = m_rdata; end
      else if (!busy && $urandom_range(0, 3) == 0) m_ack = 1'b1;
      gen = (c < N - 40);
      if ((done_now && owner_i) || !i_req) begin
        i_req = gen && ($urandom_range(0, 2) == 0); i_addr = $urandom;
      end
      if ((done_now && !owner_i) || !d_req) begin
        d_req = gen && ($urandom_range(0, 2) == 0); d_addr = $urandom;
        d_write = $urandom_range(0, 1); d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
    end
    m_ack = 1'b0;
    tests++;
    if ({busy, i_req, d_req} !== 3'b000) begin
      fails++; $display("FAIL rand_drain got busy=%b i_req=%b d_req=%b exp 0 0 0", busy, i_req, d_req);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core bus master between the fetch unit (instruction port, read-only) and the execute unit (data port, loads/stores).
- Allows one outstanding transaction at a time.
- Data port has fixed priority. A starvation guard forces an instruction grant after STARVE_LIMIT back-to-back data grants made while fetch was waiting.
- A per-transaction timeout converts a hung bus access into an error response to the owning requester.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while i_req is pending; must be ≥1.
- TIMEOUT, 64: cycles in BUSY without m_ack before error completion; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  32  fetch address
- i_ack  out  1  one-cycle completion pulse to fetch
- i_rdata  out  32  fetch read data; valid with i_ack
- i_err  out  1  error flag; valid with i_ack
- d_req  in  1  data request; held until d_ack
- d_addr  in  32  data address
- d_write  in  1  1 = store, 0 = load
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_ack  out  1  one-cycle completion pulse to execute
- d_rdata  out  32  load data; valid with d_ack
- d_err  out  1  error flag; valid with d_ack
- m_req  out  1  downstream request; held until m_ack or timeout
- m_addr  out  32  latched address
- m_write  out  1  latched write flag (0 for fetch)
- m_wdata  out  32  latched store data (0 for fetch)
- m_wstrb  out  4  latched byte enables (0 for fetch)
- m_ack  in  1  downstream completion; sampled only in BUSY
- m_rdata  in  32  downstream read data; valid with m_ack

Behaviour:
- States: IDLE, BUSY, RESPOND. Registers: owner (0 = data, 1 = instruction), starve_cnt, tmo_cnt.
- Reset (asynchronous, active-low):
  - State forced to IDLE; owner = 0; all counters = 0.
  - Every output is 0. Any in-flight transaction is abandoned; no ack is issued.
- IDLE, grant decision evaluated each cycle:
  - If d_req=1 and (i_req=0 or starve_cnt<STARVE_LIMIT): grant data.
  - Else if i_req=1: grant instruction.
  - Else: stay in IDLE.
- On a grant:
  - Latch the owner's address/write/wdata/wstrb into the m_* registers; tmo_cnt=0; go to BUSY.
  - starve_cnt: +1 on a data grant with i_req=1 (saturating at STARVE_LIMIT); cleared on an instruction grant, or on a data grant with i_req=0.
- BUSY:
  - m_req=1 and m_* fields are stable for the whole state.
  - If m_ack=1 at a clock edge: latch m_rdata, err=0; go to RESPOND.
  - Else if TIMEOUT≠0 and tmo_cnt==TIMEOUT-1: latch rdata=0, err=1; go to RESPOND.
  - Otherwise tmo_cnt increments.
- RESPOND:
  - m_req=0. The owner's ack=1 for exactly this cycle, with rdata/err from the latches.
  - The non-owner's ack, rdata and err are all 0. Next state is IDLE unconditionally.
- Requester contract: the requester drops req in the cycle after it sees ack.
  - Since the arbiter spends that cycle in IDLE, a req still high from the same requester is a new request.
  - Requester inputs are ignored outside IDLE.
- Latency:
  - req seen at edge N → m_req high N+1 … → m_ack edge M → owner ack high cycle M+1 → IDLE at M+2.
  - Minimum is 3 cycles per transaction with a zero-wait slave (m_ack high in the first BUSY cycle).
- m_ack in IDLE or RESPOND is ignored (a late ack after a timeout is dropped).
- Simultaneous i_req and d_req with starve_cnt==STARVE_LIMIT: the instruction wins, then starve_cnt=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, slave acks in first BUSY cycle with m_rdata=0xDEADBEEF.
  → m_req high in cycle 1 with m_addr=0x100, m_write=0; i_ack=1, i_rdata=0xDEADBEEF, i_err=0 in cycle 2; d_ack stays 0.
- Store: d_req=1, d_write=1, d_addr=0x2000, d_wdata=0x12345678, d_wstrb=0xF, slave adds 3 wait states.
  → m_* fields stable for 4 BUSY cycles; d_ack pulses once, in the cycle after m_ack.
- Contention: i_req and d_req both held high continuously, STARVE_LIMIT=4.
  → grant order D,D,D,D,I,D,D,D,D,I.
  → starve_cnt resets to 0 on each I grant; neither requester is starved.
- Timeout: TIMEOUT=8, slave never acks.
  → m_req high for exactly 8 cycles; then d_ack=1, d_err=1, d_rdata=0.
  → a late m_ack in the following IDLE cycle produces no extra ack.
- Reset mid-operation: assert reset during BUSY (asynchronous, between edges).
  → all outputs go to 0 immediately. After release with i_req=1, a fresh instruction grant occurs and starve_cnt starts at 0.
- Back-to-back fetches from a zero-wait slave: i_req re-asserted in the cycle after i_ack for addresses 0x0, 0x4, 0x8.
  → each completes in 3 cycles; addresses appear on m_addr in order.
